// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS datapath and its controllers: opcodes, functs,
// select enums, ALU operations and the multicycle FSM state set. Honours MIPS_JAL_EN.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] F_SLL = 6'b000000;
   localparam logic [5:0] F_SRL = 6'b000010;
   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_SLL = 4'b1000,
      ALU_SRL = 4'b1001
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      SRCB_RT    = 2'd0,
      SRCB_FOUR  = 2'd1,
      SRCB_IMM   = 2'd2,
      SRCB_IMMSH = 2'd3
   } srcb_t;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'd0,
      PCSRC_ALUOUT = 2'd1,
      PCSRC_JUMP   = 2'd2
   } pcsrc_t;

   typedef enum logic [1:0] {
      DST_RT = 2'd0,
      DST_RD = 2'd1,
      DST_RA = 2'd2
   } regdst_t;

   typedef enum logic [1:0] {
      M2R_ALUOUT = 2'd0,
      M2R_MDR    = 2'd1,
      M2R_PC     = 2'd2
   } memtoreg_t;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_RTYPE_EX,
      S_RTYPE_WB,
      S_ADDI_EX,
      S_ADDI_WB,
      S_BRANCH,
      S_JUMP,
      S_JAL
   } state_t;

   // Moore control word held in a register alongside the state.
   typedef struct packed {
      logic      memreq;
      logic      memwe;
      logic      iord;
      logic      irwrite;
      logic      pcwrite;
      logic      branch;
      logic      regwrite;
      logic      done;
      regdst_t   regdst;
      memtoreg_t memtoreg;
      logic      alusrca;
      srcb_t     alusrcb;
      pcsrc_t    pcsrc;
      alu_ctrl_t alu;
   } ctrl_t;

   function automatic logic opcode_known(input logic [5:0] op);
      logic known;
      case (op)
         OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: known = 1'b1;
`ifdef MIPS_JAL_EN
         OP_JAL:                                       known = 1'b1;
`endif
         default:                                      known = 1'b0;
      endcase
      return known;
   endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Unified instruction/data memory handshake between the multicycle controller
// (master) and the memory (slave).
interface mips_mc_ctrl_if;
   logic mem_req;
   logic mem_we;
   logic mem_ready;

   modport master (output mem_req, output mem_we, input mem_ready);
   modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/mips_alu_dec.sv
// R-type funct to ALU operation decoder; flags functs the datapath cannot execute.
module mips_alu_dec
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   output alu_ctrl_t  alu_ctrl,
   output logic       bad
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      bad      = 1'b0;
      case (funct)
         F_ADD:   alu_ctrl = ALU_ADD;
         F_SUB:   alu_ctrl = ALU_SUB;
         F_AND:   alu_ctrl = ALU_AND;
         F_OR:    alu_ctrl = ALU_OR;
         F_SLT:   alu_ctrl = ALU_SLT;
         F_SLL:   alu_ctrl = ALU_SLL;
         F_SRL:   alu_ctrl = ALU_SRL;
         default: bad      = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM sharing one memory port through a req/ready handshake.
// Define MIPS_JAL_EN to add the jal instruction (r31 link write).
module mips_mc_ctrl
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [5:0]        opcode,
   input  logic [5:0]        funct,
   input  logic              zero,
   mips_mc_ctrl_if.master    mem,
   output logic              IorD,
   output logic              IRWrite,
   output logic              PCEn,
   output logic              RegWrite,
   output logic [1:0]        RegDst,
   output logic [1:0]        MemtoReg,
   output logic              ALUSrcA,
   output logic [1:0]        ALUSrcB,
   output logic [1:0]        PCSrc,
   output logic [3:0]        ALUControl,
   output logic              instr_done,
   output logic              illegal_op
);

`ifdef MIPS_JAL_EN
   localparam logic [1:0] SELMASK = 2'b11;
`else
   localparam logic [1:0] SELMASK = 2'b01;
`endif

   state_t    state;
   state_t    nxt;
   ctrl_t     ctl;
   alu_ctrl_t rt_alu;
   logic      funct_bad;
   logic      illegal;
   logic      run;
   logic      grant;

   mips_alu_dec u_alu_dec (
      .funct    (funct),
      .alu_ctrl (rt_alu),
      .bad      (funct_bad)
   );

   function automatic ctrl_t state_ctrl(input state_t s, input alu_ctrl_t rtop);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.memreq  = 1'b1;
            c.irwrite = 1'b1;
            c.pcwrite = 1'b1;
            c.alusrcb = SRCB_FOUR;
            c.alu     = ALU_ADD;
            c.pcsrc   = PCSRC_ALU;
         end
         S_DECODE: begin
            c.alusrcb = SRCB_IMMSH;
            c.alu     = ALU_ADD;
         end
         S_MEMADR: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_IMM;
            c.alu     = ALU_ADD;
         end
         S_MEMRD: begin
            c.memreq = 1'b1;
            c.iord   = 1'b1;
         end
         S_MEMWB: begin
            c.regwrite = 1'b1;
            c.regdst   = DST_RT;
            c.memtoreg = M2R_MDR;
            c.done     = 1'b1;
         end
         S_MEMWR: begin
            c.memreq = 1'b1;
            c.memwe  = 1'b1;
            c.iord   = 1'b1;
            c.done   = 1'b1;
         end
         S_RTYPE_EX: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_RT;
            c.alu     = rtop;
         end
         S_RTYPE_WB: begin
            c.regwrite = 1'b1;
            c.regdst   = DST_RD;
            c.memtoreg = M2R_ALUOUT;
            c.done     = 1'b1;
         end
         S_ADDI_EX: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_IMM;
            c.alu     = ALU_ADD;
         end
         S_ADDI_WB: begin
            c.regwrite = 1'b1;
            c.regdst   = DST_RT;
            c.memtoreg = M2R_ALUOUT;
            c.done     = 1'b1;
         end
         S_BRANCH: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_RT;
            c.alu     = ALU_SUB;
            c.pcsrc   = PCSRC_ALUOUT;
            c.branch  = 1'b1;
            c.done    = 1'b1;
         end
         S_JUMP: begin
            c.pcwrite = 1'b1;
            c.pcsrc   = PCSRC_JUMP;
            c.done    = 1'b1;
         end
         S_JAL: begin
            c.pcwrite  = 1'b1;
            c.pcsrc    = PCSRC_JUMP;
            c.regwrite = 1'b1;
            c.regdst   = DST_RA;
            c.memtoreg = M2R_PC;
            c.done     = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

   // An R-type with an unknown funct is rejected here so no write-back state is entered.
   assign illegal = !opcode_known(opcode) || ((opcode == OP_RTYPE) && funct_bad);

   always_comb begin
      nxt = state;
      case (state)
         S_FETCH:    if (mem.mem_ready) nxt = S_DECODE;
         S_DECODE: begin
            if (illegal) begin
               nxt = S_FETCH;
            end else begin
               case (opcode)
                  OP_LW, OP_SW: nxt = S_MEMADR;
                  OP_RTYPE:     nxt = S_RTYPE_EX;
                  OP_BEQ:       nxt = S_BRANCH;
                  OP_ADDI:      nxt = S_ADDI_EX;
                  OP_J:         nxt = S_JUMP;
`ifdef MIPS_JAL_EN
                  OP_JAL:       nxt = S_JAL;
`endif
                  default:      nxt = S_FETCH;
               endcase
            end
         end
         S_MEMADR:   nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:    if (mem.mem_ready) nxt = S_MEMWB;
         S_MEMWR:    if (mem.mem_ready) nxt = S_FETCH;
         S_RTYPE_EX: nxt = S_RTYPE_WB;
         S_ADDI_EX:  nxt = S_ADDI_WB;
         default:    nxt = S_FETCH;
      endcase
   end

   // The control word is registered together with the state it belongs to.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
         ctl   <= state_ctrl(S_FETCH, ALU_ADD);
      end else begin
         state <= nxt;
         ctl   <= state_ctrl(nxt, rt_alu);
      end
   end

   // In memory states the write enables and done wait for mem_ready.
   assign run   = ~reset;
   assign grant = ~ctl.memreq | mem.mem_ready;

   assign mem.mem_req = run & ctl.memreq;
   assign mem.mem_we  = run & ctl.memwe;
   assign IorD        = run & ctl.iord;
   assign IRWrite     = run & ctl.irwrite & grant;
   assign PCEn        = run & ((ctl.pcwrite & grant) | (ctl.branch & zero));
   assign RegWrite    = run & ctl.regwrite & grant;
   assign RegDst      = run ? (ctl.regdst & SELMASK) : 2'b00;
   assign MemtoReg    = run ? (ctl.memtoreg & SELMASK) : 2'b00;
   assign ALUSrcA     = run & ctl.alusrca;
   assign ALUSrcB     = run ? ctl.alusrcb : 2'b00;
   assign PCSrc       = run ? ctl.pcsrc : 2'b00;
   assign ALUControl  = run ? ctl.alu : 4'b0000;
   assign instr_done  = run & ctl.done & grant;
   assign illegal_op  = run & (state == S_DECODE) & illegal;

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multicycle control FSM that sequences the team's MIPS datapath (PC register, register file, ALU, sign-extend/shift, branch/jump muxes) over several cycles per instruction. It shares one unified instruction/data memory port through a req/ready handshake. It decodes the instruction register's opcode and funct fields and drives every datapath select and write-enable. It sits between the top-level CPU wrapper and the datapath, replacing the single-cycle combinational decoder.

## Interface
Parameters:
- none (all encodings come from the shared package)

Ports:
- clk  in  1  system clock
- reset  in  1  reset; one clock; reset is synchronous and active-high
- opcode  in  6  Instr[31:26] from the instruction register
- funct  in  6  Instr[5:0] from the instruction register
- zero  in  1  ALU ZeroFlag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request; held until mem_ready
- mem_we  out  1  write strobe, valid with mem_req
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- IRWrite  out  1  load instruction register
- PCEn  out  1  PC load enable = PCWrite | (Branch & zero)
- RegWrite  out  1  register file write
- RegDst  out  2  0 = rt, 1 = rd, 2 = r31
- MemtoReg  out  2  0 = ALUOut, 1 = memory data register, 2 = PC
- ALUSrcA  out  1  0 = PC, 1 = rs data
- ALUSrcB  out  2  0 = rt data, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
- PCSrc  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- ALUControl  out  4  ALU operation
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode or funct

## Operation
- Moore FSM. Outputs are decoded from the state; mem_ready gates IRWrite, PCEn and RegWrite in the memory states. While reset is high, all outputs are 0.
- States and transitions:
  - FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALU ADD, PCSrc=0. On mem_ready: IRWrite=1, PCWrite=1, go to DECODE. Otherwise stay.
  - DECODE: ALUSrcA=0, ALUSrcB=3, ADD (branch target into ALUOut). Next state by opcode:
    - 100011 or 101011 -> MEMADR
    - 000000 -> RTYPE_EX
    - 000100 -> BRANCH
    - 001000 -> ADDI_EX
    - 000010 -> JUMP
    - 000011 -> JAL (only with macro)
    - anything else -> illegal_op=1, FETCH
  - MEMADR: ALUSrcA=1, ALUSrcB=2, ADD. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD: mem_req=1, IorD=1. On mem_ready go to MEMWB.
  - MEMWB: RegWrite=1, RegDst=0, MemtoReg=1, done. Go to FETCH.
  - MEMWR: mem_req=1, mem_we=1, IorD=1. On mem_ready: done, go to FETCH.
  - RTYPE_EX: ALUSrcA=1, ALUSrcB=0, ALUControl from funct. Go to RTYPE_WB.
  - RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0, done. Go to FETCH.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=2, ADD. Go to ADDI_WB.
  - ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0, done. Go to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=0, SUB, PCSrc=1, Branch=1, done. Go to FETCH.
  - JUMP: PCWrite=1, PCSrc=2, done. Go to FETCH.
- funct decode:
  - 100000 ADD
  - 100010 SUB
  - 100100 AND
  - 100101 OR
  - 101010 SLT
  - 000000 SLL
  - 000010 SRL
  - An unsupported funct is detected in DECODE: illegal_op=1, return to FETCH, no register write.
- ALUControl encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLL 1000, SRL 1001.

## Timing
- Cycle counts with a zero-wait memory (mem_ready high in the same cycle as mem_req):
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
- Each wait cycle (mem_req high, mem_ready low) adds one cycle.
- While waiting, mem_req and the address selects are held stable, and no other write enable is asserted.
- mem_ready arriving while mem_req is low is ignored.
- Reset mid-instruction: the next state is FETCH and in-flight write enables are dropped that cycle. A memory access abandoned by reset is the memory's responsibility.
- instr_done and illegal_op never assert in the same cycle.

## Configuration
- MIPS_JAL_EN defined:
  - Opcode 000011 goes DECODE -> JAL.
  - JAL asserts PCWrite=1, PCSrc=2, RegWrite=1, RegDst=2, MemtoReg=2 (writes PC+4 to r31) and done, then goes to FETCH. Cycle count is 3.
- MIPS_JAL_EN undefined:
  - Opcode 000011 is illegal.
  - The upper bits of RegDst and MemtoReg are tied to 0.

## Structure
- Shared package mips_pkg holds:
  - opcode and funct constants
  - the ALUControl enum
  - the ALUSrcB, PCSrc, RegDst and MemtoReg select enums
  - the FSM state enum
- The datapath and any future pipeline controller import the same package.
- One sub-module, mips_alu_dec: combinational funct -> ALUControl plus an illegal flag, reused by the FSM in RTYPE_EX and DECODE.

## Test plan
- Reset held 2 cycles, then released, mem_ready=1 -> the first cycle after release is FETCH with mem_req=1, IRWrite=1, PCEn=1; during reset all outputs are 0.
- lw (opcode 100011), zero-wait memory -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; instr_done on cycle 5; RegWrite=1, MemtoReg=1 in MEMWB only.
- sw with mem_ready low for 3 cycles in MEMWR -> mem_req=1, mem_we=1, IorD=1 held for 4 cycles; instr_done on the ready cycle; total 7 cycles.
- beq with zero=1, then beq with zero=0 -> PCEn=1 in BRANCH only for the first; PCSrc=1 in both.
- R-type with funct 101010 -> ALUControl=0111 in RTYPE_EX. Funct 111111 -> illegal_op pulse in DECODE, no RegWrite, next state FETCH.
- Opcode 000011 -> with MIPS_JAL_EN: RegWrite=1, RegDst=2, MemtoReg=2, PCSrc=2 in JAL. Without it: illegal_op=1.
